serial_queue_core: RTL and testbench

SERIAL_QUEUE_CORE -- requirements
Module: serial_queue_core

---
 rtl/serial_queue_core.sv | 193 +++++++++++++++++++
 tb/tb_serial_queue_core.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_queue_core.sv
// Serial-to-parallel deserializer feeding a circular word queue.
// Bits are sampled on a divided tick; the queue is serviced on a second, slower tick.

module serial_queue_tick #(
    parameter int DIV = 5
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

module serial_queue_core #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int DES_DIV = 5,
    parameter int Q_DIV   = 50
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       data_in,
    input  logic                       write_in,
    input  logic                       dequeue_in,
    output logic                       status_out,
    output logic [DATA_W-1:0]          data_out,
    output logic [$clog2(DEPTH+1)-1:0] len_out,
    output logic                       ack_out,
    output logic                       overrun_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } des_state_t;

    logic des_tick;
    logic q_tick;

    des_state_t        state_q;
    des_state_t        state_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [BW-1:0]     bit_cnt_q;
    logic [BW-1:0]     bit_cnt_d;
    logic              overrun_d;

    logic              word_valid;
    logic              enq;
    logic              deq;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;

    serial_queue_tick #(.DIV(DES_DIV)) u_des_tick (
        .clock (clock),
        .reset (reset),
        .tick  (des_tick)
    );

    serial_queue_tick #(.DIV(Q_DIV)) u_q_tick (
        .clock (clock),
        .reset (reset),
        .tick  (q_tick)
    );

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    assign word_valid  = (state_q == HOLD);
    assign status_out  = (state_q != IDLE);
    assign deq         = q_tick && dequeue_in && (len_out != '0);
    // A dequeue in the same tick frees the slot, so a full queue can still accept.
    assign enq         = q_tick && word_valid && ((len_out < LW'(DEPTH)) || deq);
    assign ack_out     = enq;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            overrun_out <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            overrun_out <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        overrun_d = overrun_out;
        case (state_q)
            IDLE: begin
                if (des_tick && write_in) begin
                    shift_d   = DATA_W'(data_in);
                    bit_cnt_d = BW'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (des_tick) begin
                    if (write_in) begin
                        shift_d   = {shift_q[DATA_W-2:0], data_in};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BW'(DATA_W - 1)) begin
                            state_d = HOLD;
                        end
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end
                end
            end
            HOLD: begin
                // The assembled word is still waiting, so any new bit has nowhere to go.
                if (des_tick && write_in) begin
                    overrun_d = 1'b1;
                end
                if (enq) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            mem[tail] <= shift_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            len_out  <= '0;
            data_out <= '0;
        end else begin
            if (enq) begin
                tail <= ptr_next(tail);
            end
            if (deq) begin
                head     <= ptr_next(head);
                data_out <= mem[head];
            end
            case ({enq, deq})
                2'b10:   len_out <= len_out + 1'b1;
                2'b01:   len_out <= len_out - 1'b1;
                default: len_out <= len_out;
            endcase
        end
    end

    a_len_bounded: assert property (@(posedge clock) disable iff (!reset)
        len_out <= LW'(DEPTH));

    a_enq_on_tick: assert property (@(posedge clock) disable iff (!reset)
        enq |-> (q_tick && word_valid));

endmodule

// File: tb/tb_serial_queue_core.sv
// Self-checking bench for serial_queue_core: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the serial/queue behaviour.

module tb_serial_queue_core;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 5;
    localparam int DES_DIV = 3;
    localparam int Q_DIV   = 7;
    localparam int LW      = $clog2(DEPTH + 1);

    logic              clock      = 1'b0;
    logic              reset      = 1'b0;
    logic              data_in    = 1'b0;
    logic              write_in   = 1'b0;
    logic              dequeue_in = 1'b0;
    logic              status_out;
    logic [DATA_W-1:0] data_out;
    logic [LW-1:0]     len_out;
    logic              ack_out;
    logic              overrun_out;

    int checks = 0;
    int errors = 0;

    serial_queue_core #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .DES_DIV (DES_DIV),
        .Q_DIV   (Q_DIV)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .write_in    (write_in),
        .dequeue_in  (dequeue_in),
        .status_out  (status_out),
        .data_out    (data_out),
        .len_out     (len_out),
        .ack_out     (ack_out),
        .overrun_out (overrun_out)
    );

    always #5 clock = ~clock;

    // Reference model: clocks-since-reset counters, a word accumulator and a plain queue.
    int                m_dcnt = 0;
    int                m_qcnt = 0;
    int                m_mode = 0;
    int                m_bits = 0;
    logic [DATA_W-1:0] m_word = '0;
    logic [DATA_W-1:0] m_dout = '0;
    logic [DATA_W-1:0] m_q[$];
    bit                m_ovr  = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_dcnt = 0; m_qcnt = 0; m_mode = 0; m_bits = 0;
            m_word = '0; m_dout = '0; m_ovr = 1'b0;
            m_q.delete();
        end else begin : model_step
            bit dt, qt, d, e;
            dt = (m_dcnt == DES_DIV - 1);
            qt = (m_qcnt == Q_DIV - 1);
            m_dcnt = dt ? 0 : m_dcnt + 1;
            m_qcnt = qt ? 0 : m_qcnt + 1;
            d = qt && dequeue_in && (m_q.size() > 0);
            e = qt && (m_mode == 2) && ((m_q.size() < DEPTH) || d);
            if (d) m_dout = m_q.pop_front();
            if (e) m_q.push_back(m_word);
            if (m_mode == 2) begin
                if (dt && write_in) m_ovr = 1'b1;
                if (e) m_mode = 0;
            end else if (dt) begin
                if (write_in) begin
                    if (m_mode == 0) begin m_word = '0; m_bits = 0; end
                    m_word = (m_word << 1) | DATA_W'(data_in);
                    m_bits++;
                    m_mode = (m_bits == DATA_W) ? 2 : 1;
                end else begin
                    m_mode = 0;
                end
            end
        end
    end

    // Every clock, ack_out must match the enqueue rule evaluated on the model state.
    int dut_acks = 0;
    int ack_err  = 0;
    always begin
        @(negedge clock);
        #2;
        if (reset) begin : ack_mon
            bit exp_ack;
            exp_ack = (m_qcnt == Q_DIV - 1) && (m_mode == 2) &&
                      ((m_q.size() < DEPTH) || (dequeue_in && m_q.size() > 0));
            if (ack_out === 1'b1) dut_acks++;
            if (ack_out !== exp_ack) ack_err++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; write_in = 1'b0; data_in = 1'b0; dequeue_in = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_des_tick();
        do @(negedge clock); while (m_dcnt != DES_DIV - 1);
    endtask

    task automatic wait_q_tick();
        do @(negedge clock); while (m_qcnt != Q_DIV - 1);
    endtask

    // Sends the low n bits of w, MSB first, one per deserializer tick.
    task automatic send_bits(input logic [DATA_W-1:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            wait_des_tick();
            data_in  = w[i];
            write_in = 1'b1;
        end
        @(negedge clock);
        write_in = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic dequeue_once();
        wait_q_tick();
        dequeue_in = 1'b1;
        @(negedge clock);
        dequeue_in = 1'b0;
        #1;
    endtask

    task automatic wait_status_low(input string name);
        int cyc = 0;
        #1;
        while (status_out !== 1'b0 && cyc < 4 * Q_DIV + 4 * DES_DIV) begin
            @(negedge clock); #1; cyc++;
        end
        checks++;
        if (status_out !== 1'b0) begin
            errors++;
            $display("FAIL %s: status_out=%b, expected 0 within %0d clocks", name, status_out, cyc);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks += 5;
        if (status_out !== 1'b0)  begin errors++; $display("FAIL reset_status: got %b exp 0", status_out); end
        if (data_out !== '0)      begin errors++; $display("FAIL reset_data: got %h exp 00", data_out); end
        if (len_out !== '0)       begin errors++; $display("FAIL reset_len: got %0d exp 0", len_out); end
        if (ack_out !== 1'b0)     begin errors++; $display("FAIL reset_ack: got %b exp 0", ack_out); end
        if (overrun_out !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b exp 0", overrun_out); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_single_word();
        int cyc = 0;
        do_reset();
        wait_des_tick();
        data_in = 1'b1; write_in = 1'b1;
        @(negedge clock); #1;
        checks++;
        if (status_out !== 1'b1) begin errors++; $display("FAIL a5_status_first_bit: got %b exp 1", status_out); end
        send_bits(8'h25, 7);
        #1;
        while (ack_out !== 1'b1 && cyc < 2 * Q_DIV) begin @(negedge clock); #1; cyc++; end
        checks += 3;
        if (ack_out !== 1'b1)    begin errors++; $display("FAIL a5_ack_seen: got %b exp 1", ack_out); end
        if (status_out !== 1'b1) begin errors++; $display("FAIL a5_status_at_ack: got %b exp 1", status_out); end
        if (len_out !== LW'(0))  begin errors++; $display("FAIL a5_len_at_ack: got %0d exp 0", len_out); end
        @(negedge clock); #1;
        checks += 3;
        if (status_out !== 1'b0) begin errors++; $display("FAIL a5_status_after: got %b exp 0", status_out); end
        if (len_out !== LW'(1))  begin errors++; $display("FAIL a5_len_after: got %0d exp 1", len_out); end
        if (ack_out !== 1'b0)    begin errors++; $display("FAIL a5_ack_width: got %b exp 0", ack_out); end
        dequeue_once();
        checks += 2;
        if (data_out !== 8'hA5)  begin errors++; $display("FAIL a5_data: got %h exp a5", data_out); end
        if (len_out !== LW'(0))  begin errors++; $display("FAIL a5_len_drained: got %0d exp 0", len_out); end
    endtask

    task automatic test_fifo_order();
        logic [DATA_W-1:0] exp_d [3] = '{8'h11, 8'h22, 8'h22};
        int                exp_l [3] = '{1, 0, 0};
        do_reset();
        send_bits(8'h11, 8); wait_status_low("fifo_enq1");
        send_bits(8'h22, 8); wait_status_low("fifo_enq2");
        checks++;
        if (len_out !== LW'(2)) begin errors++; $display("FAIL fifo_len2: got %0d exp 2", len_out); end
        for (int i = 0; i < 3; i++) begin
            dequeue_once();
            checks += 2;
            if (data_out !== exp_d[i]) begin errors++; $display("FAIL fifo_data%0d: got %h exp %h", i, data_out, exp_d[i]); end
            if (len_out !== LW'(exp_l[i])) begin errors++; $display("FAIL fifo_len%0d: got %0d exp %0d", i, len_out, exp_l[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] words[$];
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] exp_w;
        int                acks0;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            w = DATA_W'($urandom);
            words.push_back(w);
            send_bits(w, DATA_W);
            wait_status_low("bp_fill");
        end
        w = DATA_W'($urandom);
        send_bits(w, DATA_W);
        repeat (3 * Q_DIV) @(negedge clock);
        #1;
        checks += 3;
        if (len_out !== LW'(DEPTH)) begin errors++; $display("FAIL bp_len_full: got %0d exp %0d", len_out, DEPTH); end
        if (status_out !== 1'b1)    begin errors++; $display("FAIL bp_status_hold: got %b exp 1", status_out); end
        if (overrun_out !== 1'b0)   begin errors++; $display("FAIL bp_overrun_early: got %b exp 0", overrun_out); end
        send_bits(DATA_W'(2'b10), 2);
        #1;
        checks += 2;
        if (overrun_out !== 1'b1)   begin errors++; $display("FAIL bp_overrun_set: got %b exp 1", overrun_out); end
        if (status_out !== 1'b1)    begin errors++; $display("FAIL bp_status_still: got %b exp 1", status_out); end
        acks0 = dut_acks;
        dequeue_once();
        words.push_back(w);
        exp_w = words.pop_front();
        checks += 4;
        if (data_out !== exp_w)      begin errors++; $display("FAIL bp_first_out: got %h exp %h", data_out, exp_w); end
        if (len_out !== LW'(DEPTH))  begin errors++; $display("FAIL bp_len_swap: got %0d exp %0d", len_out, DEPTH); end
        if (dut_acks !== acks0 + 1)  begin errors++; $display("FAIL bp_ack_on_deq: got %0d acks exp %0d", dut_acks - acks0, 1); end
        if (status_out !== 1'b0)     begin errors++; $display("FAIL bp_status_release: got %b exp 0", status_out); end
        for (int i = 0; i < DEPTH; i++) begin
            dequeue_once();
            exp_w = words.pop_front();
            checks++;
            if (data_out !== exp_w) begin errors++; $display("FAIL bp_drain%0d: got %h exp %h", i, data_out, exp_w); end
        end
        checks += 2;
        if (len_out !== LW'(0))    begin errors++; $display("FAIL bp_len_empty: got %0d exp 0", len_out); end
        if (overrun_out !== 1'b1)  begin errors++; $display("FAIL bp_overrun_sticky: got %b exp 1", overrun_out); end
    endtask

    task automatic test_abort();
        int acks0;
        do_reset();
        send_bits(8'h5A, 8);
        wait_status_low("abort_prefill");
        acks0 = dut_acks;
        send_bits(3'b101, 3);
        repeat (DES_DIV + 1) @(negedge clock);
        #1;
        checks++;
        if (status_out !== 1'b0) begin errors++; $display("FAIL abort_status: got %b exp 0", status_out); end
        repeat (2 * Q_DIV) @(negedge clock);
        #1;
        checks += 3;
        if (dut_acks !== acks0)   begin errors++; $display("FAIL abort_no_ack: got %0d acks exp 0", dut_acks - acks0); end
        if (len_out !== LW'(1))   begin errors++; $display("FAIL abort_len: got %0d exp 1", len_out); end
        if (overrun_out !== 1'b0) begin errors++; $display("FAIL abort_overrun: got %b exp 0", overrun_out); end
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] expq[$];
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] exp_w;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            w = DATA_W'($urandom);
            expq.push_back(w);
            send_bits(w, DATA_W);
            wait_status_low("wrap_prefill");
        end
        for (int i = 0; i < 14; i++) begin
            w = DATA_W'($urandom);
            expq.push_back(w);
            send_bits(w, DATA_W);
            wait_status_low("wrap_enq");
            dequeue_once();
            exp_w = expq.pop_front();
            checks += 2;
            if (data_out !== exp_w) begin errors++; $display("FAIL wrap_data%0d: got %h exp %h", i, data_out, exp_w); end
            if (len_out !== LW'(expq.size())) begin errors++; $display("FAIL wrap_len%0d: got %0d exp %0d", i, len_out, expq.size()); end
        end
    endtask

    task automatic test_reset_midframe();
        int acks0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_bits(DATA_W'(8'h81 + 8'(i * 16)), DATA_W);
            wait_status_low("mid_fill");
        end
        dequeue_once();
        checks++;
        if (len_out !== LW'(3)) begin errors++; $display("FAIL mid_len3: got %0d exp 3", len_out); end
        for (int i = 0; i < 4; i++) begin
            wait_des_tick();
            data_in = 1'b1; write_in = 1'b1;
        end
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        checks += 5;
        if (status_out !== 1'b0)  begin errors++; $display("FAIL mid_status: got %b exp 0", status_out); end
        if (data_out !== '0)      begin errors++; $display("FAIL mid_data: got %h exp 00", data_out); end
        if (len_out !== '0)       begin errors++; $display("FAIL mid_len: got %0d exp 0", len_out); end
        if (ack_out !== 1'b0)     begin errors++; $display("FAIL mid_ack: got %b exp 0", ack_out); end
        if (overrun_out !== 1'b0) begin errors++; $display("FAIL mid_overrun: got %b exp 0", overrun_out); end
        write_in = 1'b0; data_in = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        acks0 = dut_acks;
        repeat (3 * Q_DIV) @(negedge clock);
        #1;
        checks += 2;
        if (dut_acks !== acks0)  begin errors++; $display("FAIL mid_no_enq: got %0d acks exp 0", dut_acks - acks0); end
        if (len_out !== LW'(0))  begin errors++; $display("FAIL mid_len_after: got %0d exp 0", len_out); end
        send_bits(8'h3C, 8);
        wait_status_low("mid_resume");
        dequeue_once();
        checks++;
        if (data_out !== 8'h3C) begin errors++; $display("FAIL mid_resume_data: got %h exp 3c", data_out); end
    endtask

    task automatic test_random();
        int deq_pct;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            #1;
            checks += 4;
            if (len_out !== LW'(m_q.size())) begin errors++; $display("FAIL rnd_len@%0d: got %0d exp %0d", i, len_out, m_q.size()); end
            if (data_out !== m_dout)         begin errors++; $display("FAIL rnd_data@%0d: got %h exp %h", i, data_out, m_dout); end
            if (status_out !== (m_mode != 0)) begin errors++; $display("FAIL rnd_status@%0d: got %b exp %b", i, status_out, m_mode != 0); end
            if (overrun_out !== m_ovr)       begin errors++; $display("FAIL rnd_overrun@%0d: got %b exp %b", i, overrun_out, m_ovr); end
            deq_pct  = (i < 2000) ? 15 : 70;
            write_in = ($urandom_range(0, 15) != 0);
            data_in  = 1'($urandom);
            dequeue_in = ($urandom_range(0, 99) < deq_pct);
        end
        @(negedge clock);
        write_in = 1'b0; dequeue_in = 1'b0;
        #3;
        checks++;
        if (ack_err !== 0) begin errors++; $display("FAIL ack_timing: %0d cycles with wrong ack_out, exp 0", ack_err); end
    endtask

    initial begin
        $display("[TB] serial_queue_core bench start");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        test_reset();
        test_single_word();
        test_fifo_order();
        test_backpressure();
        test_abort();
        test_wrap();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
